// File: rtl/cfa_pass_sequencer_if.sv
// cfa_pass_sequencer_if: control, pixel-input and read/write port bundle for cfa_pass_sequencer.
// The stall signal only exists when the build macro CFA_STALL_EN is defined.
interface cfa_pass_sequencer_if #(
  parameter int DATA_W = 12,
  parameter int ROW_W  = 11,
  parameter int COL_W  = 11,
  parameter int ADDR_W = 22
);
  logic              start;
`ifdef CFA_STALL_EN
  logic              stall;
`endif
  logic [ROW_W-1:0]  row_max;
  logic [COL_W-1:0]  col_max;
  logic [1:0]        pattern_sel;
  logic [DATA_W-1:0] raw_c;
  logic [DATA_W-1:0] est_g;
  logic [DATA_W-1:0] est_r_g;
  logic [DATA_W-1:0] est_b_g;
  logic [DATA_W-1:0] est_rb;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              pass_id;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_en;
  logic [DATA_W-1:0] wr_g;
  logic [DATA_W-1:0] wr_r;
  logic [DATA_W-1:0] wr_b;
  logic              busy;
  logic              done;

  // Frame controller / kernel side.
  modport master (
`ifdef CFA_STALL_EN
    output stall,
`endif
    output start, row_max, col_max, pattern_sel,
    output raw_c, est_g, est_r_g, est_b_g, est_rb,
    input  rd_addr, rd_valid, pass_id, wr_addr, wr_en, wr_g, wr_r, wr_b, busy, done
  );

  // Sequencer side.
  modport slave (
`ifdef CFA_STALL_EN
    input  stall,
`endif
    input  start, row_max, col_max, pattern_sel,
    input  raw_c, est_g, est_r_g, est_b_g, est_rb,
    output rd_addr, rd_valid, pass_id, wr_addr, wr_en, wr_g, wr_r, wr_b, busy, done
  );
endinterface

// File: rtl/cfa_pass_sequencer.sv
// cfa_pass_sequencer: two-pass Bayer demosaic sequencer. A green pass and then a red/blue
// pass walk the frame in raster order, each address travelling with its Bayer symbol through
// a LAT-deep pipeline until the kernel results are steered onto the per-channel write ports.
// Build macro CFA_STALL_EN adds a stall input that freezes counters, pipeline, FSM and writes.
module cfa_pass_sequencer #(
  parameter int DATA_W = 12,
  parameter int ROW_W  = 11,
  parameter int COL_W  = 11,
  parameter int ADDR_W = 22,
  parameter int LAT    = 4
) (
  input logic clk,
  input logic rst,
  cfa_pass_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, G_PASS, G_DRAIN, RB_PASS, RB_DRAIN, DONE} seqStateT;

  localparam logic [1:0] SYM_GRN = 2'b01;
  localparam logic [1:0] SYM_RED = 2'b10;
  localparam logic [1:0] SYM_BLU = 2'b11;

  seqStateT          state, nextState;
  logic              hold;
  logic [ROW_W-1:0]  rowMax, rowCnt;
  logic [COL_W-1:0]  colMax, colCnt;
  logic [1:0]        pattern;
  logic [ADDR_W-1:0] addrCnt;
  logic              issuing, lastIssue, pipeEmpty, rbPass, effRow, effCol;
  logic [1:0]        symNow;
  logic [LAT-1:0]    pipeVld;
  logic [ADDR_W-1:0] pipeAddr [LAT];
  logic [1:0]        pipeSym  [LAT];
  logic [2:0]        wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrG, wrR, wrB;

`ifdef CFA_STALL_EN
  assign hold = bus.stall;
`else
  assign hold = 1'b0;
`endif

  assign issuing   = (state == G_PASS) || (state == RB_PASS);
  assign lastIssue = issuing && (rowCnt == rowMax) && (colCnt == colMax);
  assign pipeEmpty = (pipeVld == '0);
  assign rbPass    = (state == RB_PASS) || (state == RB_DRAIN);

  // The pattern select flips row/column parity so every pattern reduces to RGGB.
  assign effRow = rowCnt[0] ^ pattern[1];
  assign effCol = colCnt[0] ^ pattern[0];
  assign symNow = (!effRow && !effCol) ? SYM_RED :
                  ( effRow &&  effCol) ? SYM_BLU : SYM_GRN;

  // State register; while stalled the FSM holds, which also defers done.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)        state <= IDLE;
    else if (!hold) state <= nextState;
  end

  // Next-state logic: pass until the last address issues, drain until the pipeline empties.
  // NOTE: nextState is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (bus.start) nextState = G_PASS;
      G_PASS:   if (lastIssue) nextState = G_DRAIN;
      G_DRAIN:  if (pipeEmpty) nextState = RB_PASS;
      RB_PASS:  if (lastIssue) nextState = RB_DRAIN;
      RB_DRAIN: if (pipeEmpty) nextState = DONE;
      DONE:     nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Frame geometry capture at start, and raster counters that sit at zero outside the passes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rowMax  <= '0;
      colMax  <= '0;
      pattern <= '0;
      rowCnt  <= '0;
      colCnt  <= '0;
      addrCnt <= '0;
    end else if (!hold) begin
      if (state == IDLE && bus.start) begin
        rowMax  <= bus.row_max;
        colMax  <= bus.col_max;
        pattern <= bus.pattern_sel;
      end
      if (issuing) begin
        addrCnt <= addrCnt + 1'b1;
        if (colCnt == colMax) begin
          colCnt <= '0;
          rowCnt <= rowCnt + 1'b1;
        end else begin
          colCnt <= colCnt + 1'b1;
        end
      end else begin
        addrCnt <= '0;
        rowCnt  <= '0;
        colCnt  <= '0;
      end
    end
  end

  // Issue register (slot 0 drives rd_addr) followed by the address/symbol/valid delay line.
  // NOTE: the address and symbol slots are reset too because slot 0 is the visible rd_addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipeVld <= '0;
      for (int k = 0; k < LAT; k++) begin
        pipeAddr[k] <= '0;
        pipeSym[k]  <= '0;
      end
    end else if (!hold) begin
      pipeVld <= {pipeVld[LAT-2:0], issuing};
      if (issuing) begin
        pipeAddr[0] <= addrCnt;
        pipeSym[0]  <= symNow;
      end
      for (int k = 1; k < LAT; k++) begin
        pipeAddr[k] <= pipeAddr[k-1];
        pipeSym[k]  <= pipeSym[k-1];
      end
    end
  end

  // Write-back steering: the slot at stage LAT-1 samples the kernel inputs; idle buses hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrEn   <= '0;
      wrAddr <= '0;
      wrG    <= '0;
      wrR    <= '0;
      wrB    <= '0;
    end else if (!hold) begin
      wrEn <= 3'b000;
      if (pipeVld[LAT-1]) begin
        wrAddr <= pipeAddr[LAT-1];
        if (!rbPass) begin
          case (pipeSym[LAT-1])
            SYM_RED: begin wrEn <= 3'b011; wrG <= bus.est_g; wrR <= bus.raw_c; end
            SYM_BLU: begin wrEn <= 3'b101; wrG <= bus.est_g; wrB <= bus.raw_c; end
            default: begin wrEn <= 3'b001; wrG <= bus.raw_c; end
          endcase
        end else begin
          case (pipeSym[LAT-1])
            SYM_RED: begin wrEn <= 3'b100; wrB <= bus.est_rb; end
            SYM_BLU: begin wrEn <= 3'b010; wrR <= bus.est_rb; end
            default: begin wrEn <= 3'b110; wrR <= bus.est_r_g; wrB <= bus.est_b_g; end
          endcase
        end
      end
    end
  end

  assign bus.rd_addr  = pipeAddr[0];
  assign bus.rd_valid = pipeVld[0] & ~hold;
  assign bus.pass_id  = rbPass;
  assign bus.wr_addr  = wrAddr;
  assign bus.wr_en    = wrEn & {3{~hold}};
  assign bus.wr_g     = wrG;
  assign bus.wr_r     = wrR;
  assign bus.wr_b     = wrB;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE) && !hold;

endmodule

// File: tb/tb_cfa_pass_sequencer.sv
// tb_cfa_pass_sequencer: directed frames checked by an issue/write scoreboard.
// Build with CFA_STALL_EN defined to also exercise the stall sequence.
module tb_cfa_pass_sequencer;
  localparam int DATA_W = 12;
  localparam int ROW_W  = 11;
  localparam int COL_W  = 11;
  localparam int ADDR_W = 22;
  localparam int LAT    = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              pass;
    byte               colour;
    int                cyc;
  } issueT;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   doneCount;
  int   startCyc;
  bit   latencyCheck;
  bit   stallAt [int];
  issueT expIssue [$];
  issueT expWrite [$];
  logic [DATA_W-1:0] mG, mR, mB;
  string patName [4];

  cfa_pass_sequencer_if #(.DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W)) bus ();

  cfa_pass_sequencer #(
    .DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W), .LAT(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] dataFn(input int c, input int k);
    int v;
    v = c * 37 + k * 613 + ((c * (k + 1)) ^ 91);
    return v[DATA_W-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Kernel inputs are a known function of the cycle number.
  initial begin
    bus.raw_c = '0; bus.est_g = '0; bus.est_r_g = '0; bus.est_b_g = '0; bus.est_rb = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.raw_c   = dataFn(cyc, 0);
      bus.est_g   = dataFn(cyc, 1);
      bus.est_r_g = dataFn(cyc, 2);
      bus.est_b_g = dataFn(cyc, 3);
      bus.est_rb  = dataFn(cyc, 4);
    end
  end

  task automatic monitorCycle();
    issueT e;
    int L;
    logic [2:0] en;
    bit curStall;
    curStall = 1'b0;
`ifdef CFA_STALL_EN
    curStall = bus.stall;
`endif
    stallAt[cyc] = curStall;
    if (curStall) begin
      check("stall_rd_valid", bus.rd_valid, 0);
      check("stall_wr_en", bus.wr_en, 0);
    end
    if (bus.rd_valid === 1'b1) begin
      check("issue_expected", expIssue.size() > 0, 1);
      if (expIssue.size() > 0) begin
        e = expIssue.pop_front();
        check("rd_addr", bus.rd_addr, e.addr);
        check("pass_id", bus.pass_id, e.pass);
        if (latencyCheck) check("issue_cycle", cyc, e.cyc);
        e.cyc = cyc;
        expWrite.push_back(e);
      end
    end
    if (bus.wr_en !== 3'b000) begin
      check("write_expected", expWrite.size() > 0, 1);
      if (expWrite.size() > 0) begin
        e = expWrite.pop_front();
        L = cyc - 1;
        while (stallAt.exists(L) && stallAt[L]) L--;
        if (!e.pass) begin
          if (e.colour == "R")      begin en = 3'b011; mG = dataFn(L, 1); mR = dataFn(L, 0); end
          else if (e.colour == "B") begin en = 3'b101; mG = dataFn(L, 1); mB = dataFn(L, 0); end
          else                      begin en = 3'b001; mG = dataFn(L, 0); end
        end else begin
          if (e.colour == "G")      begin en = 3'b110; mR = dataFn(L, 2); mB = dataFn(L, 3); end
          else if (e.colour == "R") begin en = 3'b100; mB = dataFn(L, 4); end
          else                      begin en = 3'b010; mR = dataFn(L, 4); end
        end
        check("wr_en", bus.wr_en, en);
        check("wr_addr", bus.wr_addr, e.addr);
        check("wr_g", bus.wr_g, mG);
        check("wr_r", bus.wr_r, mR);
        check("wr_b", bus.wr_b, mB);
        if (latencyCheck) check("write_cycle", cyc, e.cyc + LAT);
      end
    end
    if (bus.done === 1'b1) doneCount++;
  endtask

  always @(negedge clk) monitorCycle();

  // Pushes the expected issue order of both passes and pulses start for one cycle.
  task automatic launch(input int rmax, input int cmax, input int pat);
    int n;
    string s;
    issueT e;
    n = (rmax + 1) * (cmax + 1);
    s = patName[pat];
    @(posedge clk);
    #1;
    startCyc = cyc;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < n; a++) begin
        e.addr   = ADDR_W'(a);
        e.pass   = p[0];
        e.colour = s.getc(2 * ((a / (cmax + 1)) % 2) + (a % (cmax + 1)) % 2);
        e.cyc    = startCyc + 2 + p * (n + LAT + 1) + a;
        expIssue.push_back(e);
      end
    end
    bus.start       = 1'b1;
    bus.row_max     = ROW_W'(rmax);
    bus.col_max     = COL_W'(cmax);
    bus.pattern_sel = 2'(pat);
  endtask

  task automatic runFrame(input int rmax, input int cmax, input int pat,
                          input int midStartOff, input int stallOff, input int stallLen);
    int n, frameLen, doneBefore;
    bit gotDone;
    n = (rmax + 1) * (cmax + 1);
    frameLen = 2 * (n + LAT + 1) + 1;
    latencyCheck = (stallLen == 0);
    doneBefore = doneCount;
    launch(rmax, cmax, pat);
    gotDone = 1'b0;
    for (int k = 1; k <= frameLen + stallLen + 20 && !gotDone; k++) begin
      @(posedge clk);
      #1;
      bus.start = (midStartOff > 0) && (cyc == startCyc + midStartOff);
      if (bus.start) begin
        bus.row_max     = '0;
        bus.col_max     = '0;
        bus.pattern_sel = 2'(3 - pat);
      end
`ifdef CFA_STALL_EN
      bus.stall = (stallLen > 0) && (cyc >= startCyc + stallOff) && (cyc < startCyc + stallOff + stallLen);
`endif
      @(negedge clk);
`ifdef CFA_STALL_EN
      if (bus.stall) check("stall_rd_addr_hold", bus.rd_addr, stallOff - 2);
`endif
      if (bus.done === 1'b1) begin
        gotDone = 1'b1;
        check("done_cycle", cyc - startCyc, frameLen + stallLen);
        check("busy_at_done", bus.busy, 1);
      end
    end
    check("done_seen", gotDone, 1);
    @(negedge clk);
    check("busy_after_done", bus.busy, 0);
    check("done_one_cycle", bus.done, 0);
    repeat (LAT + 2) @(negedge clk);
    check("issues_consumed", expIssue.size(), 0);
    check("writes_consumed", expWrite.size(), 0);
    check("done_pulse_count", doneCount - doneBefore, 1);
  endtask

  // Main directed sequence.
  initial begin
    bit found;
    int doneBefore;
    patName = '{"RGGB", "GRBG", "GBRG", "BGGR"};
    vectors = 0; miscompares = 0; doneCount = 0; latencyCheck = 1'b1;
    mG = '0; mR = '0; mB = '0;
    rst = 1'b1;
    bus.start = 1'b0; bus.row_max = '0; bus.col_max = '0; bus.pattern_sel = '0;
`ifdef CFA_STALL_EN
    bus.stall = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rd_valid", bus.rd_valid, 0);
    check("reset_rd_addr", bus.rd_addr, 0);
    check("reset_wr_en", bus.wr_en, 0);
    check("reset_wr_addr", bus.wr_addr, 0);
    check("reset_wr_g", bus.wr_g, 0);
    check("reset_wr_r", bus.wr_r, 0);
    check("reset_wr_b", bus.wr_b, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_pass_id", bus.pass_id, 0);
    rst = 1'b0;

    runFrame(3, 3, 0, -1, -1, 0);   // RGGB 4x4
    runFrame(1, 1, 2, -1, -1, 0);   // GBRG 2x2
    runFrame(0, 0, 1, -1, -1, 0);   // 1x1 frame
    runFrame(3, 3, 3, 6, -1, 0);    // start and new geometry mid G_PASS are ignored
    runFrame(2, 4, 0, -1, -1, 0);   // 3x5, column wrap
`ifdef CFA_STALL_EN
    runFrame(3, 3, 0, -1, 9, 3);    // stall 3 cycles while rd_addr shows 7
`endif

    // Abort: reset while RB_PASS shows address 5.
    latencyCheck = 1'b1;
    launch(3, 3, 0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (bus.rd_valid === 1'b1 && bus.pass_id === 1'b1 && bus.rd_addr === ADDR_W'(5)) found = 1'b1;
    end
    check("abort_point_reached", found, 1);
    doneBefore = doneCount;
    rst = 1'b1;
    @(negedge clk);
    check("abort_rd_valid", bus.rd_valid, 0);
    check("abort_rd_addr", bus.rd_addr, 0);
    check("abort_wr_en", bus.wr_en, 0);
    check("abort_wr_addr", bus.wr_addr, 0);
    check("abort_wr_data", {bus.wr_g, bus.wr_r, bus.wr_b}, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_pass_id", bus.pass_id, 0);
    rst = 1'b0;
    expIssue.delete();
    expWrite.delete();
    mG = '0; mR = '0; mB = '0;
    repeat (30) @(negedge clk);
    check("abort_no_done", doneCount - doneBefore, 0);
    check("abort_stays_idle", bus.busy, 0);

    runFrame(1, 2, 1, -1, -1, 0);   // GRBG 2x3 after abort

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
